// File: rtl/xalu_muldiv.sv
// Multiply/divide unit: owns HI/LO, fixed-latency MULT/MULTU/DIV/DIVU, Busy for the stall unit.
// Optional macro XALU_MADD_EN adds MADD/MADDU (ops 9/10) accumulating onto HI/LO.
module xalu_muldiv #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  XALUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] XALUOut
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
`ifdef XALU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
`endif

    logic [CntW-1:0] cnt_q;
    logic [31:0]     pend_hi_q, pend_lo_q;
    logic            pend_wr_q;

    logic [63:0]     prod_s, prod_u;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, q_mag, r_mag;
    logic [63:0]     res;
    logic            res_wr;
    logic            op_valid;
    logic [CntW-1:0] lat;
    logic            accept;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
    end

    // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        a_neg = A[31];
        b_neg = B[31];
        a_mag = a_neg ? (~A + 32'd1) : A;
        b_mag = (B == 32'd0) ? 32'd1 : (b_neg ? (~B + 32'd1) : B);
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
    end

    always_comb begin
        res      = {HI, LO};
        res_wr   = 1'b1;
        op_valid = 1'b1;
        lat      = CntW'(MUL_CYCLES);
        case (XALUOp)
            OpMult:  res = prod_s;
            OpMultu: res = prod_u;
            OpDiv: begin
                lat    = CntW'(DIV_CYCLES);
                res_wr = (B != 32'd0);
                res    = {a_neg ? (~r_mag + 32'd1) : r_mag,
                          (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag};
            end
            OpDivu: begin
                lat    = CntW'(DIV_CYCLES);
                res_wr = (B != 32'd0);
                res    = (B != 32'd0) ? {A % B, A / B} : {HI, LO};
            end
`ifdef XALU_MADD_EN
            OpMadd:  res = {HI, LO} + prod_s;
            OpMaddu: res = {HI, LO} + prod_u;
`endif
            default: op_valid = 1'b0;
        endcase
    end

    assign accept = Start && !Busy && op_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            Busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q     <= lat;
                Busy      <= 1'b1;
                pend_hi_q <= res[63:32];
                pend_lo_q <= res[31:0];
                pend_wr_q <= res_wr;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                Busy  <= (cnt_q != CntW'(1));
                if (cnt_q == CntW'(1) && pend_wr_q) begin
                    HI <= pend_hi_q;
                    LO <= pend_lo_q;
                end
            end
            // Busy is high on every commit edge, so direct writes never collide with a commit.
            if (!Busy && XALUOp == OpMthi) HI <= A;
            if (!Busy && XALUOp == OpMtlo) LO <= A;
        end
    end

    always_comb begin
        case (XALUOp)
            OpMfhi:  XALUOut = HI;
            OpMflo:  XALUOut = LO;
            default: XALUOut = '0;
        endcase
    end

endmodule

// File: tb/tb_xalu_muldiv.sv
// Scoreboard bench for xalu_muldiv: random ops against a 64-bit arithmetic reference model.
module tb_xalu_muldiv;

    localparam int MulCycles = 5;
    localparam int DivCycles = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  XALUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO, XALUOut;

    xalu_muldiv #(
        .MUL_CYCLES(MulCycles),
        .DIV_CYCLES(DivCycles)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .XALUOp (XALUOp),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .XALUOut(XALUOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hi_m, lo_m;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every falling Busy is a commit; check HI/LO and the Busy length.
    int run = 0;
    bit prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            run  = 0;
            prev = 1'b0;
        end else begin
            if (Busy) begin
                run++;
            end else if (prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", HI, LO);
                end else begin
                    e = sb.pop_front();
                    chk("commit_hi", HI, e.hi);
                    chk("commit_lo", LO, e.lo);
                    chk("busy_len", 32'(run), 32'(e.cyc));
                end
                run = 0;
            end
            prev = Busy;
        end
    end

    task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc = {hi_m, lo_m};
        longint      sa, sbv, q, r;
        int          cyc = MulCycles;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            4'd1: acc = 64'(sa * sbv);
            4'd2: acc = {32'b0, a} * {32'b0, b};
            4'd3: begin
                cyc = DivCycles;
                if (b != 0) begin
                    q   = sa / sbv;
                    r   = sa % sbv;
                    acc = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                cyc = DivCycles;
                if (b != 0) acc = {a % b, a / b};
            end
            4'd9:  acc = acc + 64'(sa * sbv);
            4'd10: acc = acc + {32'b0, a} * {32'b0, b};
            default: ;
        endcase
        hi_m = acc[63:32];
        lo_m = acc[31:0];
        sb.push_back('{acc[63:32], acc[31:0], cyc});
    endtask

    // Called at a negedge with the unit idle; returns one negedge after the accept edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        predict(op, a, b);
        XALUOp = op;
        A      = a;
        B      = b;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        XALUOp = 4'd0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (Busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (Busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got Busy=1 after %0d cycles expected 0", k);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        XALUOp = op;
        A      = a;
        @(negedge clk);
        XALUOp = 4'd0;
        if (op == 4'd5) hi_m = a;
        else            lo_m = a;
        chk("mt_hi", HI, hi_m);
        chk("mt_lo", LO, lo_m);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          max_op;
        logic [3:0]  op;
        logic [31:0] ra, rb;

        reset = 1'b1; Start = 1'b0; A = '0; B = '0; XALUOp = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", XALUOut, 32'd0);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        mon_en = 1'b1;

        launch(4'd1, 32'hFFFFFFFD, 32'd5); wait_idle();
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFF1);
        launch(4'd4, 32'd7, 32'd2); wait_idle();
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);
        launch(4'd3, 32'hFFFFFFF9, 32'd2); wait_idle();
        chk("div_neg_hi", HI, 32'hFFFFFFFF);
        chk("div_neg_lo", LO, 32'hFFFFFFFD);
        launch(4'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();
        chk("div_ovf_hi", HI, 32'd0);
        chk("div_ovf_lo", LO, 32'h80000000);

        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        launch(4'd3, 32'd1234, 32'd0); wait_idle();
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);

        XALUOp = 4'd8; #1 chk("mflo", XALUOut, 32'h22);
        XALUOp = 4'd7; #1 chk("mfhi", XALUOut, 32'h11);
        XALUOp = 4'd0; #1 chk("op_none_out", XALUOut, 32'd0);
        XALUOp = 4'd12; #1 chk("op_12_out", XALUOut, 32'd0);
        XALUOp = 4'd0;
        @(negedge clk);

        // Second Start mid-DIV must not restart or replace the operation.
        launch(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        XALUOp = 4'd1; A = 32'd9; B = 32'd9; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd0;
        wait_idle();
        chk("restart_hi", HI, 32'd2);
        chk("restart_lo", LO, 32'd14);

        launch(4'd1, 32'd3, 32'd4);
        XALUOp = 4'd5; A = 32'hDEAD;
        @(negedge clk);
        XALUOp = 4'd0;
        chk("mthi_busy", HI, 32'd2);
        wait_idle();
        chk("mult_after_mthi_lo", LO, 32'd12);

`ifdef XALU_MADD_EN
        mt(4'd5, 32'd0);
        mt(4'd6, 32'hFFFFFFFF);
        launch(4'd10, 32'd1, 32'd1); wait_idle();
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
        max_op = 10;
`else
        XALUOp = 4'd9; A = 32'd5; B = 32'd5; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd0;
        chk("madd_off_busy", 32'(Busy), 32'd0);
        chk("madd_off_lo", LO, lo_m);
        max_op = 8;
`endif

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, max_op));
            ra = rnd32();
            rb = rnd32();
            case (op)
                4'd5, 4'd6: mt(op, ra);
                4'd7: begin
                    XALUOp = op; #1 chk("rnd_mfhi", XALUOut, hi_m);
                    XALUOp = 4'd0; @(negedge clk);
                end
                4'd8: begin
                    XALUOp = op; #1 chk("rnd_mflo", XALUOut, lo_m);
                    XALUOp = 4'd0; @(negedge clk);
                end
                default: begin
                    launch(op, ra, rb);
                    wait_idle();
                end
            endcase
        end

        // Reset mid-DIV: abandon the operation, clear state immediately, no late commit.
        mt(4'd5, 32'h55);
        mon_en = 1'b0;
        launch(4'd3, 32'd99, 32'd5);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (15) @(negedge clk);
        chk("rst_late_busy", 32'(Busy), 32'd0);
        chk("rst_late_hi", HI, 32'd0);
        chk("rst_late_lo", LO, 32'd0);
        mon_en = 1'b1;

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
